// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the sqrt job scheduler.
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD,
        WAIT
    } sched_state_t;

    localparam logic [15:0] FP16_QNAN = 16'hFE00;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_PINF = 1;
    localparam int FLAG_NINF = 0;

endpackage

// File: rtl/sqrt_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search for a requester starts at ptr and wraps.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    logic [N_REQ-1:0] rotated;
    logic [ID_W:0]    sum;

    // Rotate so that bit 0 is the requester at ptr, then take the first set bit.
    always_comb begin
        rotated   = N_REQ'({req, req} >> ptr);
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && rotated[i]) begin
                grant_any = 1'b1;
                sum = {1'b0, ptr} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(N_REQ)) begin
                    sum = sum - (ID_W+1)'(N_REQ);
                end
                grant_idx = sum[ID_W-1:0];
            end
        end
        grant = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/sqrt_job_scheduler.sv
// Round-robin scheduler sharing one fp16 sqrt core between N_REQ requesters.
// Optional watchdog: define SQRT_SCHED_TIMEOUT_EN to abort jobs stuck in WAIT.
module sqrt_job_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_REQ-1:0]      REQ_VALID,
    input  logic [16*N_REQ-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]      REQ_READY,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [ID_W-1:0]       RSP_ID,
    output logic [15:0]           RSP_DATA,
    output logic [2:0]            RSP_FLAGS,
    output logic                  RSP_ERR,
    output logic                  CORE_ENABLE,
    output logic [15:0]           CORE_DOUT,
    output logic                  CORE_OE,
    input  logic [15:0]           CORE_DIN,
    input  logic                  CORE_RESULT,
    input  logic                  CORE_IS_NAN,
    input  logic                  CORE_IS_PINF,
    input  logic                  CORE_IS_NINF
);

    if (ID_W < $clog2(N_REQ) || N_REQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("sqrt_job_scheduler: invalid N_REQ/ID_W/TIMEOUT combination");
    end

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  tag;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic             can_grant;
    logic [15:0]      req_operand;
    logic [2:0]       core_flags;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req       (REQ_VALID),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The single-entry response buffer must be empty before a new job is accepted.
    assign can_grant = (state == IDLE) && !RSP_VALID;
    assign REQ_READY = can_grant ? grant : '0;

    always_comb begin
        req_operand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                req_operand = REQ_DATA[16*i +: 16];
            end
        end
        core_flags            = '0;
        core_flags[FLAG_NAN]  = CORE_IS_NAN;
        core_flags[FLAG_PINF] = CORE_IS_PINF;
        core_flags[FLAG_NINF] = CORE_IS_NINF;
    end

`ifdef SQRT_SCHED_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    logic [WDOG_W-1:0] wdog_cnt;
    logic              rsp_err_q;
    assign RSP_ERR = rsp_err_q;
`else
    assign RSP_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= CLEAR;
            rr_ptr      <= '0;
            tag         <= '0;
            RSP_VALID   <= 1'b0;
            RSP_ID      <= '0;
            RSP_DATA    <= '0;
            RSP_FLAGS   <= '0;
            CORE_ENABLE <= 1'b0;
            CORE_OE     <= 1'b0;
            CORE_DOUT   <= '0;
`ifdef SQRT_SCHED_TIMEOUT_EN
            wdog_cnt    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            if (RSP_VALID && RSP_READY) begin
                RSP_VALID <= 1'b0;
            end
            case (state)
                CLEAR: begin
                    CORE_ENABLE <= 1'b0;
                    state       <= IDLE;
                end
                IDLE: begin
                    if (can_grant && grant_any) begin
                        tag         <= grant_idx;
                        CORE_DOUT   <= req_operand;
                        rr_ptr      <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                        CORE_ENABLE <= 1'b1;
                        CORE_OE     <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    // The core takes over the bus from the next edge, so release it now.
                    CORE_OE <= 1'b0;
                    state   <= WAIT;
`ifdef SQRT_SCHED_TIMEOUT_EN
                    wdog_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (CORE_RESULT) begin
                        RSP_DATA    <= CORE_DIN;
                        RSP_FLAGS   <= core_flags;
                        RSP_ID      <= tag;
                        RSP_VALID   <= 1'b1;
                        CORE_ENABLE <= 1'b0;
                        state       <= CLEAR;
`ifdef SQRT_SCHED_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (wdog_cnt == WDOG_W'(TIMEOUT - 1)) begin
                        RSP_DATA    <= FP16_QNAN;
                        RSP_FLAGS   <= 3'(1 << FLAG_NAN);
                        RSP_ID      <= tag;
                        RSP_VALID   <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        CORE_ENABLE <= 1'b0;
                        state       <= CLEAR;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
